// File: rtl/pps_phase_meter_if.sv
`default_nettype none
// ============================================================================
//  Module      : pps_phase_meter_if
//  Description : Measurement bus from the PPS phase meter to the loop filter.
//                master = phase meter, slave = loop filter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pps_phase_meter_if;
    logic [23:0] Measure_Phase;   // signed phase error, two's complement
    logic        Measure_Done;    // one-cycle strobe, phase valid alongside
    logic        Gps_Valid;       // 1 while tracking the GPS reference

    modport master (output Measure_Phase, Measure_Done, Gps_Valid);
    modport slave  (input  Measure_Phase, Measure_Done, Gps_Valid);
endinterface
`default_nettype wire

// File: rtl/pps_phase_meter.sv
`default_nettype none
// ============================================================================
//  Module      : pps_phase_meter
//  Description : Divides CLK_SYS into a local 1PPS, times the GPS 1PPS edge
//                against it and emits a signed 24-bit phase error with a
//                one-cycle Measure_Done strobe. Declares GPS loss after
//                LOST_SECS local seconds without an accepted edge.
//                Optional build macro COARSE_ALIGN_EN: on acquisition the
//                local counter is reloaded so the next phase is ~0.
//  Revision    : 1.0 - initial release
// ============================================================================
module pps_phase_meter #(
    parameter int CNT_MAX      = 10_000_000,
    parameter int SYNC_COMP    = 2,
    parameter int PPS_WIDTH    = 1000,
    parameter int BLANK_CYCLES = 5_000_000,
    parameter int LOST_SECS    = 3
) (
    input  logic              CLK_SYS,
    input  logic              CLK_RST,
    input  logic              Gps_Pps,
    output logic              Local_Pps,
    pps_phase_meter_if.master meas
);

    localparam int          c_BLANK_W   = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int          c_MISS_W    = (LOST_SECS > 1) ? $clog2(LOST_SECS + 1) : 1;
    localparam logic [24:0] c_CNT_MAX   = 25'(CNT_MAX);
    localparam logic [24:0] c_HALF      = 25'(CNT_MAX / 2);
    localparam logic [23:0] c_CNT_LAST  = 24'(CNT_MAX - 1);
    localparam logic [23:0] c_SYNC      = 24'(SYNC_COMP);
    localparam logic [23:0] c_PPS_W     = 24'(PPS_WIDTH);
    localparam logic [c_BLANK_W-1:0] c_BLANK_LOAD = c_BLANK_W'(BLANK_CYCLES - 1);
    localparam logic [c_MISS_W-1:0]  c_MISS_LAST  = c_MISS_W'(LOST_SECS - 1);

    typedef enum logic [0:0] {
        ST_LOST  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    state_t                 r_state;
    logic [23:0]            r_cnt;
    logic                   r_local_pps;
    logic [2:0]             r_sync;
    logic [c_BLANK_W-1:0]   r_blank;
    logic [c_MISS_W-1:0]    r_miss;
    logic                   r_seen;
    logic                   r_done;
    logic [23:0]            r_phase;
    logic                   r_valid;

    logic                   w_detect;
    logic                   w_accept;
    logic                   w_wrap;
    logic [23:0]            w_cnt_next;
    logic [24:0]            w_capt;
    logic [24:0]            w_phase;

    // Bits 0/1 form the synchronizer, bit 2 is the delayed copy for edge detect.
    assign w_detect = r_sync[1] & ~r_sync[2];
    assign w_accept = w_detect && (r_blank == '0);
    assign w_wrap   = (r_cnt == c_CNT_LAST);

    // Next local count: free-running wrap, optionally reloaded on acquisition.
    always_comb begin
        w_cnt_next = w_wrap ? 24'd0 : r_cnt + 24'd1;
`ifdef COARSE_ALIGN_EN
        // Reload so the next GPS edge lands at count SYNC_COMP, i.e. phase 0.
        if (w_accept && (r_state == ST_LOST)) begin
            w_cnt_next = 24'(SYNC_COMP + 1);
        end
`else
`endif
    end

    // Captured count with synchronizer latency removed, then folded to +/- half second.
    always_comb begin
        if (r_cnt >= c_SYNC) begin
            w_capt = {1'b0, r_cnt} - {1'b0, c_SYNC};
        end else begin
            w_capt = {1'b0, r_cnt} + c_CNT_MAX - {1'b0, c_SYNC};
        end
        if (w_capt <= c_HALF) begin
            w_phase = 25'd0 - w_capt;       // local edge came first
        end else begin
            w_phase = c_CNT_MAX - w_capt;   // GPS edge came first
        end
    end

    // Local second counter and registered local 1PPS derived from the next count.
    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            r_cnt       <= 24'd0;
            r_local_pps <= 1'b1;
        end else begin
            r_cnt       <= w_cnt_next;
            r_local_pps <= (w_cnt_next < c_PPS_W);
        end
    end

    // GPS 1PPS synchronizer plus edge-detect stage.
    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], Gps_Pps};
        end
    end

    // Blanking window after each accepted edge to reject glitches and double pulses.
    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            r_blank <= '0;
        end else if (w_accept) begin
            r_blank <= c_BLANK_LOAD;
        end else if (r_blank != '0) begin
            r_blank <= r_blank - c_BLANK_W'(1);
        end
    end

    // Lock state machine: arm on first edge, measure on later edges, hold over on loss.
    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            r_state <= ST_LOST;
            r_miss  <= '0;
            r_seen  <= 1'b0;
            r_done  <= 1'b0;
            r_phase <= 24'd0;
            r_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // An edge on the tick cycle belongs to the second that is ending.
            if (w_accept) begin
                r_seen <= !w_wrap;
            end else if (w_wrap) begin
                r_seen <= 1'b0;
            end
            case (r_state)
                ST_LOST: begin
                    if (w_accept) begin
                        r_state <= ST_TRACK;
                        r_valid <= 1'b1;
                        r_miss  <= '0;
                    end
                end
                ST_TRACK: begin
                    if (w_accept) begin
                        r_done  <= 1'b1;
                        r_phase <= 24'(w_phase);
                        r_miss  <= '0;
                    end else if (w_wrap && !r_seen) begin
                        r_miss <= r_miss + c_MISS_W'(1);
                        if (r_miss == c_MISS_LAST) begin
                            r_state <= ST_LOST;
                            r_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_LOST;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign Local_Pps          = r_local_pps;
    assign meas.Measure_Phase = r_phase;
    assign meas.Measure_Done  = r_done;
    assign meas.Gps_Valid     = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_pps_phase_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pps_phase_meter
//  Description : Directed, table-driven bench for pps_phase_meter with
//                small parameters (1000-cycle second).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pps_phase_meter;

    localparam int CNT_MAX      = 1000;
    localparam int SYNC_COMP    = 2;
    localparam int PPS_WIDTH    = 10;
    localparam int BLANK_CYCLES = 500;
    localparam int LOST_SECS    = 3;
`ifdef COARSE_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic CLK_SYS = 1'b0;
    logic CLK_RST = 1'b0;
    logic Gps_Pps = 1'b0;
    logic Local_Pps;

    pps_phase_meter_if meas ();

    pps_phase_meter #(
        .CNT_MAX      (CNT_MAX),
        .SYNC_COMP    (SYNC_COMP),
        .PPS_WIDTH    (PPS_WIDTH),
        .BLANK_CYCLES (BLANK_CYCLES),
        .LOST_SECS    (LOST_SECS)
    ) dut (
        .CLK_SYS   (CLK_SYS),
        .CLK_RST   (CLK_RST),
        .Gps_Pps   (Gps_Pps),
        .Local_Pps (Local_Pps),
        .meas      (meas)
    );

    always #5 CLK_SYS = ~CLK_SYS;

    // d = local count on the detect cycle; arm = edge only arms the meter
    typedef struct {
        int          d;
        bit          arm;
        logic        valid;
        int          done;
        logic [23:0] phase;
    } vec_t;

    vec_t vecs [12];

    int n_cmp = 0;
    int n_bad = 0;
    int m_cnt = 0;          // model of the DUT local counter
    bit reload_pending = 1'b0;
    int pps_bad = 0;
    int pps_high = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: advance the counter model, then audit Local_Pps and Done.
    task automatic step();
        @(posedge CLK_SYS);
        #1;
        if (!CLK_RST)            m_cnt = 0;
        else if (reload_pending) m_cnt = SYNC_COMP + 1;
        else                     m_cnt = (m_cnt + 1) % CNT_MAX;
        reload_pending = 1'b0;
        if (Local_Pps !== (m_cnt < PPS_WIDTH)) pps_bad++;
        if (Local_Pps === 1'b1) pps_high++;
        if (meas.Measure_Done !== 1'b0) done_cnt++;
    endtask

    task automatic wait_cnt(input int target);
        int k = 0;
        while (m_cnt != target && k < 3000) begin
            step();
            k++;
        end
        if (m_cnt != target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_cnt: count %0d never reached, at %0d", target, m_cnt);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_local_pps"}, 32'(Local_Pps), 32'd1);
        check({tag, "_done"},      32'(meas.Measure_Done), 32'd0);
        check({tag, "_phase"},     32'(meas.Measure_Phase), 32'd0);
        check({tag, "_valid"},     32'(meas.Gps_Valid), 32'd0);
    endtask

    // Drive one GPS pulse so the detect cycle sees count v.d, then check the result.
    task automatic apply_vec(input int idx);
        vec_t v;
        int   d0;
        v = vecs[idx];
        repeat (510) step();
        wait_cnt((v.d - SYNC_COMP + CNT_MAX) % CNT_MAX);
        d0 = done_cnt;
        Gps_Pps = 1'b1;
        step();
        step();                               // detect cycle
        if (v.arm && ALIGN) reload_pending = 1'b1;
        check($sformatf("v%0d_no_early_done", idx), 32'(done_cnt - d0), 32'd0);
        step();                               // one cycle after detect
        check($sformatf("v%0d_done", idx),  32'(meas.Measure_Done), 32'(v.done));
        check($sformatf("v%0d_phase", idx), 32'(meas.Measure_Phase), 32'(v.phase));
        check($sformatf("v%0d_valid", idx), 32'(meas.Gps_Valid), 32'(v.valid));
        repeat (20) step();
        Gps_Pps = 1'b0;
        check($sformatf("v%0d_done_count", idx), 32'(done_cnt - d0), 32'(v.done));
    endtask

    initial begin
        int d0;
        int wraps;

        vecs[0]  = '{52,  1'b1, 1'b1, 0, 24'h000000};   // arms only
        vecs[1]  = '{52,  1'b0, 1'b1, 1, 24'hFFFFCE};   // -50
        vecs[2]  = '{902, 1'b0, 1'b1, 1, 24'h000064};   // +100
        vecs[3]  = '{502, 1'b0, 1'b1, 1, 24'hFFFE0C};   // exact half: -500
        vecs[4]  = '{3,   1'b0, 1'b1, 1, 24'hFFFFFF};   // -1
        vecs[5]  = '{504, 1'b0, 1'b1, 1, 24'h0001F2};   // +498
        vecs[6]  = '{1,   1'b0, 1'b1, 1, 24'h000001};   // capture wraps below zero: +1
        vecs[7]  = '{2,   1'b0, 1'b1, 1, 24'h000000};   // zero phase
        vecs[8]  = '{52,  1'b1, 1'b1, 0, 24'hFFFFCE};   // re-arm after loss, phase held
        vecs[9]  = '{52,  1'b0, 1'b1, 1, 24'hFFFFCE};
        vecs[10] = '{300, 1'b1, 1'b1, 0, 24'h000000};   // arm after reset
        if (ALIGN) vecs[11] = '{2,   1'b0, 1'b1, 1, 24'h000000};
        else       vecs[11] = '{300, 1'b0, 1'b1, 1, 24'hFFFED6};   // -298

        // Reset state
        repeat (3) step();
        check_reset_values("reset");
        CLK_RST = 1'b1;

        // Idle GPS for five seconds
        pps_high = 0;
        repeat (5000) step();
        check("idle_pps_high_cycles", 32'(pps_high), 32'd50);
        check("idle_done_count", 32'(done_cnt), 32'd0);
        check("idle_valid", 32'(meas.Gps_Valid), 32'd0);

        // Measurement table
        for (int i = 0; i < 8; i++) apply_vec(i);

        // Second pulse inside the blanking window is ignored
        repeat (77) step();
        Gps_Pps = 1'b1;
        d0 = done_cnt;
        repeat (20) step();
        Gps_Pps = 1'b0;
        repeat (5) step();
        check("blank_ignored", 32'(done_cnt - d0), 32'd0);
        check("blank_phase_hold", 32'(meas.Measure_Phase), 32'd0);
        apply_vec(1);

        // GPS loss: drop on the third edgeless tick, phase holds
        d0 = done_cnt;
        wraps = 0;
        for (int k = 0; k < 4000 && wraps < 4; k++) begin
            step();
            if (m_cnt == CNT_MAX - 1 && wraps == 3)
                check("valid_before_loss", 32'(meas.Gps_Valid), 32'd1);
            if (m_cnt == 0) wraps++;
        end
        check("valid_after_loss", 32'(meas.Gps_Valid), 32'd0);
        check("phase_hold_lost", 32'(meas.Measure_Phase), 32'hFFFFCE);
        check("no_done_during_loss", 32'(done_cnt - d0), 32'd0);
        apply_vec(8);
        apply_vec(9);

        // Reset mid-operation, then acquisition (aligned or not per build)
        CLK_RST = 1'b0;
        m_cnt = 0;
        #1;
        check_reset_values("midreset");
        step();
        step();
        CLK_RST = 1'b1;
        apply_vec(10);
        apply_vec(11);

        // Reset asserted with a Done pending
        repeat (510) step();
        wait_cnt(50);
        Gps_Pps = 1'b1;
        step();
        step();                               // detect cycle
        CLK_RST = 1'b0;
        m_cnt = 0;
        #1;
        check_reset_values("pending");
        Gps_Pps = 1'b0;
        repeat (3) step();
        CLK_RST = 1'b1;
        d0 = done_cnt;
        repeat (20) step();
        check("pending_dropped", 32'(done_cnt - d0), 32'd0);
        check("pending_valid", 32'(meas.Gps_Valid), 32'd0);

        check("local_pps_pattern_errors", 32'(pps_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
